rr_requester: RTL and testbench
===============================

# rr_requester

Requester-side agent for the 4-way round-robin arbiter with a 3-cycle-per-grant limit. Each instance owns one requester slot. It buffers words from a local producer in a small FIFO, raises `req` while data is pending, and drains one word per cycle onto the shared bus while its grant bit is high. It also flags starvation. Four instances, `ID` 0..3, sit in front of the arbiter. Their `req` bits form the arbiter's `req[3:0]`, and the arbiter's one-hot `out[3:0]` feeds every instance's `gnt`.

## Interface
Parameters:
- `ID`, 0: grant bit owned by this instance (0..3).
- `DATA_W`, 8: word width.
- `DEPTH`, 4: FIFO depth in words (power of two, ≥2).
- `STARVE_MAX`, 16: wait cycles without grant before `starve` sets.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  producer push strobe.
- `wr_data`  in  DATA_W  producer word.
- `full`  out  1  FIFO full; push ignored while high.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `req`  out  1  request to arbiter, registered.
- `gnt`  in  4  one-hot grant vector from arbiter.
- `bus_valid`  out  1  word on bus this cycle, registered.
- `bus_data`  out  DATA_W  granted word, registered.
- `starve`  out  1  sticky starvation flag.

## Operation
- **Reset** (async, any cycle including mid-transfer): FIFO emptied. `level`=0, `full`=0, `req`=0, `bus_valid`=0, `bus_data`=0, `starve`=0. State=IDLE, wait counter=0.
- **Push:** accepted when `wr_en` && !`full`. A push into an empty FIFO is not visible to pop in the same cycle, so there is no bypass.
- **Pop:** occurs when `gnt[ID]` && `level`≠0 && state≠IDLE. Head word goes to `bus_data` and `bus_valid`=1 on the next edge. Otherwise `bus_valid`=0 and `bus_data` holds its value.
- **Push and pop in the same cycle:** both occur and `level` is unchanged. When full, the push is rejected even if a pop happens that cycle.
- **Stale grant:** `gnt[ID]` seen while empty or in IDLE is ignored. This is expected, because the arbiter's grant trails request removal by one cycle.
- **Requests:** `req` is registered and equals (next `level` ≠ 0).
- **FSM:**
  - IDLE → WAIT when next level ≠ 0.
  - WAIT → XFER on `gnt[ID]` with a pop. WAIT → IDLE when next level = 0.
  - XFER → WAIT when `gnt[ID]` drops and next level ≠ 0. XFER → IDLE when next level = 0. Otherwise stay in XFER.
- **Starvation:** the wait counter increments on each WAIT cycle without `gnt[ID]`, saturating at `STARVE_MAX`. It clears on entry to XFER or IDLE. `starve` sets when the counter reaches `STARVE_MAX` and is cleared only by `rst`.
- **Widths:** FIFO pointers are $clog2(DEPTH) bits and wrap naturally. `level` carries one extra bit so a full FIFO is representable.

## Timing
- Push at edge N: `level` updates at N+1; `req` and the WAIT state are visible after N+1.
- With the arbiter as the partner: `req` rises at N+1, the arbiter state updates at N+2, and `gnt` rises after N+3. The first `bus_valid` is at N+4.
- Throughput is one word per granted cycle. At most 3 consecutive words per grant slot, as limited by the arbiter.
- `req` drops on the same edge that pops the last word. A one-cycle trailing `gnt` follows and is ignored.
- `full`, `level` and `starve` are registered-state derived, so they have no combinational path from `gnt` or `wr_en`.

## Structure
- Shared package `rr_pkg` holds:
  - `NUM_REQ`=4.
  - The requester FSM state typedef (IDLE, WAIT, XFER).
  - One-hot grant constants `GNT_0`..`GNT_3`.
- One sub-module: `rr_sync_fifo`, a parameterised DATA_W×DEPTH register FIFO with push/pop, `level` and `full`, and async active-high reset. The FSM, request, bus and starvation logic stay in `rr_requester`.

## Test plan
- **Single word:** reset, push 0xA5 at cycle 0 with `gnt`=0001 driven at cycle 3 for ID=0 → `req`=1 at cycle 1; `bus_valid`=1 with `bus_data`=0xA5 at cycle 4; `req`=0 after cycle 4; level returns to 0.
- **Fill and overflow:** push 5 words 0x01..0x05 back-to-back with no grant → `full`=1 after the 4th push, 0x05 dropped, `level`=4. A 4-cycle grant then yields 0x01..0x04 in order, and the FIFO ends empty.
- **Simultaneous push and pop at full:** `level`=4, `wr_en`=1 and `gnt[ID]`=1 → pop occurs, push rejected, `level`=3.
- **Stale grant:** `gnt[ID]` high for 2 cycles with the FIFO empty → `bus_valid` stays 0, state stays IDLE, `req` stays 0.
- **Starvation:** one word pushed, `gnt`=0 held for 16 cycles → `starve`=1 at the 16th WAIT cycle and stays 1 after a later grant drains the word. `rst` clears it.
- **Reset mid-transfer:** assert `rst` asynchronously between edges during XFER with `level`=2 → all outputs 0 immediately. After release, no `bus_valid` until a new push and grant.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter and its requester-side agents.
package rr_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER
    } req_state_e;

    localparam logic [NUM_REQ-1:0] GNT_0 = 4'b0001;
    localparam logic [NUM_REQ-1:0] GNT_1 = 4'b0010;
    localparam logic [NUM_REQ-1:0] GNT_2 = 4'b0100;
    localparam logic [NUM_REQ-1:0] GNT_3 = 4'b1000;

endpackage

// File: rtl/rr_sync_fifo.sv
// Register-based synchronous FIFO with occupancy count; pushes while full and
// pops while empty are silently ignored.
module rr_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [AW:0]       level_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q;
    logic [AW-1:0]     rdPtr_q;
    logic [AW:0]       count_q;
    logic              pushOk;
    logic              popOk;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;
    assign data_o  = mem_q[rdPtr_q];
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && (count_q != '0);

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (pushOk && !popOk) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!pushOk && popOk) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rr_requester.sv
// Requester-side agent for the 4-way round-robin arbiter: buffers producer
// words, requests the bus, drains on grant and flags starvation.
module rr_requester
    import rr_pkg::*;
#(
    parameter int ID         = 0,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    output logic               full_o,
    output logic [AW:0]        level_o,
    output logic               req_o,
    input  logic [NUM_REQ-1:0] gnt_i,
    output logic               bus_valid_o,
    output logic [DATA_W-1:0]  bus_data_o,
    output logic               starve_o
);

    req_state_e        state_q, state_d;
    logic [CW-1:0]     waitCnt_q, waitCnt_d;
    logic              req_q;
    logic              busValid_q;
    logic [DATA_W-1:0] busData_q;
    logic              starve_q;
    logic              myGnt;
    logic              pushEn;
    logic              popEn;
    logic [AW:0]       levelNext;
    logic [DATA_W-1:0] headData;

    assign myGnt  = gnt_i[ID];
    assign pushEn = wr_en_i && !full_o;
    // A grant arriving while empty or idle is the arbiter's one-cycle trailing grant.
    assign popEn  = myGnt && (level_o != '0) && (state_q != IDLE);

    rr_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pushEn),
        .data_i  (wr_data_i),
        .pop_i   (popEn),
        .data_o  (headData),
        .level_o (level_o),
        .full_o  (full_o)
    );

    always_comb begin
        levelNext = level_o;
        if (pushEn && !popEn) begin
            levelNext = level_o + (AW+1)'(1);
        end else if (!pushEn && popEn) begin
            levelNext = level_o - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (levelNext != '0) state_d = WAIT;
            end
            WAIT: begin
                if (levelNext == '0)  state_d = IDLE;
                else if (popEn)       state_d = XFER;
            end
            XFER: begin
                if (levelNext == '0)  state_d = IDLE;
                else if (!myGnt)      state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase

        // The wait count restarts whenever we leave WAIT for IDLE or XFER.
        if (state_d != WAIT) begin
            waitCnt_d = '0;
        end else if (state_q == WAIT && !myGnt && waitCnt_q != CW'(STARVE_MAX)) begin
            waitCnt_d = waitCnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            req_q      <= 1'b0;
            busValid_q <= 1'b0;
            busData_q  <= '0;
            starve_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            req_q      <= (levelNext != '0);
            busValid_q <= popEn;
            if (popEn) begin
                busData_q <= headData;
            end
            if (waitCnt_d == CW'(STARVE_MAX)) begin
                starve_q <= 1'b1;
            end
        end
    end

    assign req_o       = req_q;
    assign bus_valid_o = busValid_q;
    assign bus_data_o  = busData_q;
    assign starve_o    = starve_q;

endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester (ID=0): reset, single word, fill/overflow,
// push+pop at full, stale grant, starvation and asynchronous reset mid-transfer.
module tb_rr_requester;
    import rr_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn;
    logic [7:0] wrData;
    logic [3:0] gnt;
    logic       full;
    logic [2:0] level;
    logic       req;
    logic       busValid;
    logic [7:0] busData;
    logic       starve;

    int total = 0;
    int bad   = 0;

    rr_requester #(
        .ID         (0),
        .DATA_W     (8),
        .DEPTH      (4),
        .STARVE_MAX (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wrEn),
        .wr_data_i   (wrData),
        .full_o      (full),
        .level_o     (level),
        .req_o       (req),
        .gnt_i       (gnt),
        .bus_valid_o (busValid),
        .bus_data_o  (busData),
        .starve_o    (starve)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic [3:0] g);
        wrEn   = w;
        wrData = d;
        gnt    = g;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst    = 1'b1;
        wrEn   = 1'b0;
        wrData = 8'h00;
        gnt    = 4'b0000;
        tick();
        tick();
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_valid", 32'(busValid), 32'd0);
        checkOutput("rst_data", 32'(busData), 32'd0);
        checkOutput("rst_starve", 32'(starve), 32'd0);
        rst = 1'b0;

        $display("[TB] single word");
        applyStimulus(1'b1, 8'hA5, 4'b0000);
        checkOutput("sw_level1", 32'(level), 32'd1);
        checkOutput("sw_req1", 32'(req), 32'd1);
        checkOutput("sw_valid0", 32'(busValid), 32'd0);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkOutput("sw_req_hold", 32'(req), 32'd1);
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("sw_valid1", 32'(busValid), 32'd1);
        checkOutput("sw_data", 32'(busData), 32'hA5);
        checkOutput("sw_req0", 32'(req), 32'd0);
        checkOutput("sw_level0", 32'(level), 32'd0);
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("sw_trail_valid", 32'(busValid), 32'd0);
        checkOutput("sw_trail_data", 32'(busData), 32'hA5);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 4'b0000);
            if (i == 3) checkOutput("fill_notfull3", 32'(full), 32'd0);
            if (i == 4) checkOutput("fill_full4", 32'(full), 32'd1);
        end
        checkOutput("fill_level", 32'(level), 32'd4);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_req", 32'(req), 32'd1);
        checkOutput("fill_novalid", 32'(busValid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 8'h00, GNT_0);
            checkOutput($sformatf("drain_valid%0d", i), 32'(busValid), 32'd1);
            checkOutput($sformatf("drain_data%0d", i), 32'(busData), 32'(i));
        end
        checkOutput("drain_level", 32'(level), 32'd0);
        checkOutput("drain_full", 32'(full), 32'd0);
        checkOutput("drain_req", 32'(req), 32'd0);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkOutput("drain_idle_valid", 32'(busValid), 32'd0);

        $display("[TB] push and pop at full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 4'b0000);
        end
        checkOutput("pp_level4", 32'(level), 32'd4);
        applyStimulus(1'b1, 8'h14, GNT_0);
        checkOutput("pp_data", 32'(busData), 32'h10);
        checkOutput("pp_level3", 32'(level), 32'd3);
        checkOutput("pp_full", 32'(full), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 8'h00, GNT_0);
            checkOutput($sformatf("pp_data%0d", i), 32'(busData), 32'(8'h10 + i));
        end
        checkOutput("pp_end_level", 32'(level), 32'd0);
        checkOutput("pp_end_req", 32'(req), 32'd0);
        applyStimulus(1'b0, 8'h00, 4'b0000);

        $display("[TB] stale grant");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, GNT_0);
            checkOutput("stale_valid", 32'(busValid), 32'd0);
            checkOutput("stale_req", 32'(req), 32'd0);
            checkOutput("stale_level", 32'(level), 32'd0);
            checkOutput("stale_data", 32'(busData), 32'h13);
        end

        $display("[TB] starvation");
        applyStimulus(1'b1, 8'h77, 4'b0000);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(1'b0, 8'h00, (k < 8) ? 4'b0000 : GNT_2);
            checkOutput($sformatf("starve_low%0d", k), 32'(starve), 32'd0);
            checkOutput($sformatf("starve_novalid%0d", k), 32'(busValid), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, GNT_2);
        applyStimulus(1'b0, 8'h00, GNT_2);
        checkOutput("starve_set", 32'(starve), 32'd1);
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("starve_pop_valid", 32'(busValid), 32'd1);
        checkOutput("starve_pop_data", 32'(busData), 32'h77);
        checkOutput("starve_sticky1", 32'(starve), 32'd1);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        checkOutput("starve_sticky2", 32'(starve), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("starve_rst_clear", 32'(starve), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] reset mid-transfer");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h21 + i), 4'b0000);
        end
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("mid_data1", 32'(busData), 32'h21);
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("mid_data2", 32'(busData), 32'h22);
        checkOutput("mid_level2", 32'(level), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_req", 32'(req), 32'd0);
        checkOutput("mid_rst_valid", 32'(busValid), 32'd0);
        checkOutput("mid_rst_data", 32'(busData), 32'd0);
        checkOutput("mid_rst_full", 32'(full), 32'd0);
        checkOutput("mid_rst_starve", 32'(starve), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, GNT_0);
            checkOutput("post_rst_valid", 32'(busValid), 32'd0);
            checkOutput("post_rst_req", 32'(req), 32'd0);
        end
        applyStimulus(1'b1, 8'h99, 4'b0000);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        applyStimulus(1'b0, 8'h00, 4'b0000);
        applyStimulus(1'b0, 8'h00, GNT_0);
        checkOutput("post_rst_new_valid", 32'(busValid), 32'd1);
        checkOutput("post_rst_new_data", 32'(busData), 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
